// File: rtl/bk_adder_checker.sv
// bk_adder_checker: valid/ready response monitor that recomputes adder sums and tallies mismatches.
module bk_adder_checker #(
  parameter int WIDTH       = 32,
  parameter int NUM_VECTORS = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] s,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH:0]   first_fail_exp,
  output logic [WIDTH:0]   first_fail_got
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic acc, clr, v1, fail_seen, mism;
  logic [WIDTH:0] exp_q, got_q;
  logic [CNT_W-1:0] idx_q, err_nx;
  assign in_ready = state == RUN;
  assign busy = (state == RUN) || (state == DRAIN);
  assign acc = in_valid && in_ready;
  assign clr = start && ((state == IDLE) || (state == DONE));
  assign mism = v1 && (exp_q != got_q);
  always_comb begin
    state_nx = clr ? RUN :
               (acc && vec_count == CNT_W'(NUM_VECTORS - 1)) ? DRAIN :
               (state == DRAIN) ? DONE : state;
    err_nx = clr ? '0 : (mism && err_count != '1) ? err_count + CNT_W'(1) : err_count;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      done           <= 1'b0;
      pass           <= 1'b0;
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
      fail_seen      <= 1'b0;
      v1             <= 1'b0;
      exp_q          <= '0;
      got_q          <= '0;
      idx_q          <= '0;
    end else begin
      state     <= state_nx;
      done      <= state_nx == DONE;
      pass      <= (state_nx == DONE) && (err_nx == '0);
      err_count <= err_nx;
      vec_count <= clr ? '0 : acc ? vec_count + CNT_W'(1) : vec_count;
      v1        <= acc;
      if (acc) begin
        exp_q <= {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
        got_q <= {co, s};
        idx_q <= vec_count;
      end
      if (clr) begin
        fail_seen      <= 1'b0;
        first_fail_idx <= '0;
        first_fail_exp <= '0;
        first_fail_got <= '0;
      end else if (mism && !fail_seen) begin
        fail_seen      <= 1'b1;
        first_fail_idx <= idx_q;
        first_fail_exp <= exp_q;
        first_fail_got <= got_q;
      end
    end
  end
endmodule

// File: tb/tb_bk_adder_checker.sv
// tb_bk_adder_checker: randomized and directed checks of the adder response monitor against a behavioural model.
module tb_bk_adder_checker;
  localparam int N = 5;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, cin = 1'b0, co = 1'b0;
  logic [31:0] a = '0, b = '0, s = '0;
  logic in_ready, busy, done, pass;
  logic [15:0] vec_count, err_count, first_fail_idx;
  logic [32:0] first_fail_exp, first_fail_got;
  int n_checks = 0, n_fail = 0;
  bit m_run = 0;
  int m_vec = 0, m_err = 0, m_fidx = 0;
  logic [32:0] m_fexp = '0, m_fgot = '0;

  bk_adder_checker #(.WIDTH(32), .NUM_VECTORS(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .s(s), .co(co), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .first_fail_idx(first_fail_idx),
    .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_vec = 0; m_err = 0; m_fidx = 0; m_fexp = '0; m_fgot = '0;
  endtask

  task automatic pulse_start(input bit clears);
    start = 1'b1;
    if (clears) begin model_clear(); m_run = 1; end
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input logic [31:0] ai, bi, input logic ci, input logic [31:0] si, input logic coi);
    logic [32:0] e, g;
    a = ai; b = bi; cin = ci; s = si; co = coi; in_valid = 1'b1;
    if (m_run) begin
      e = 33'(longint'(ai) + longint'(bi) + longint'(ci));
      g = {coi, si};
      if (e != g) begin
        if (m_err == 0) begin m_fidx = m_vec; m_fexp = e; m_fgot = g; end
        m_err++;
      end
      m_vec++;
      if (m_vec == N) m_run = 0;
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send_good(input logic [31:0] ai, bi, input logic ci);
    logic [32:0] t;
    t = 33'(longint'(ai) + longint'(bi) + longint'(ci));
    send(ai, bi, ci, t[31:0], t[32]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, busy, done, pass} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {in_ready, busy, done, pass}); end
    n_checks++;
    if ({vec_count, err_count, first_fail_idx} !== 48'd0 || {first_fail_exp, first_fail_got} !== 66'd0) begin
      n_fail++; $display("FAIL reset_counters vec %0d err %0d idx %0d exp %h got %h, all expected 0", vec_count, err_count, first_fail_idx, first_fail_exp, first_fail_got);
    end
    rst = 1'b0; m_run = 0; model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_clean(input bit bad3);
    logic [31:0] ta [N] = '{103, 79, 222, 149, 1018};
    logic [31:0] tb [N] = '{166, 156, 993, 502, 788};
    logic [31:0] ts [N] = '{269, 235, 1215, 651, 1806};
    pulse_start(1);
    for (int i = 0; i < N; i++) send(ta[i], tb[i], 1'b0, (bad3 && i == 2) ? 32'd1200 : ts[i], 1'b0);
    n_checks++;
    if ({done, busy, in_ready} !== 3'b010) begin n_fail++; $display("FAIL drain_state done/busy/ready got %b exp 010", {done, busy, in_ready}); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL done_latency got %b exp 1", done); end
    n_checks++;
    if (pass !== !bad3 || vec_count !== 16'd5 || err_count !== 16'(bad3)) begin
      n_fail++; $display("FAIL run_result pass %b vec %0d err %0d, exp pass %b vec 5 err %0d", pass, vec_count, err_count, !bad3, bad3);
    end
    n_checks++;
    if (first_fail_idx !== (bad3 ? 16'd2 : 16'd0) || first_fail_exp !== (bad3 ? 33'd1215 : 33'd0) || first_fail_got !== (bad3 ? 33'd1200 : 33'd0)) begin
      n_fail++; $display("FAIL first_fail idx %0d exp %0d got %0d", first_fail_idx, first_fail_exp, first_fail_got);
    end
  endtask

  task automatic test_carry(input logic co_bit);
    pulse_start(1);
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, co_bit);
    send_good(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < N - 2; i++) send_good($urandom, $urandom, 1'($urandom_range(1)));
    @(posedge clk); #1;
    n_checks++;
    if (pass !== co_bit || err_count !== 16'(!co_bit)) begin n_fail++; $display("FAIL carry_pass co=%b pass %b err %0d", co_bit, pass, err_count); end
    n_checks++;
    if (first_fail_exp !== (co_bit ? 33'd0 : 33'h1_0000_0000) || first_fail_got !== 33'd0) begin
      n_fail++; $display("FAIL carry_first co=%b exp_field %h got_field %h", co_bit, first_fail_exp, first_fail_got);
    end
  endtask

  task automatic test_random(input int runs);
    logic [31:0] ra, rb, t;
    logic rc;
    int waited;
    for (int r = 0; r < runs; r++) begin
      pulse_start(1);
      while (m_run) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
        if ($urandom_range(7) == 0) begin ra = '1; rb = '1; rc = 1'b1; end
        t = ra + rb + 32'(rc);
        if ($urandom_range(3) == 0) send(ra, rb, rc, t ^ (32'd1 << $urandom_range(31)), ($urandom_range(1) == 1));
        else send_good(ra, rb, rc);
        if ($urandom_range(2) == 0) begin @(posedge clk); #1; end
      end
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL rand_done_timeout run %0d", r); end
      n_checks++;
      if (vec_count !== 16'(m_vec) || err_count !== 16'(m_err) || pass !== (m_err == 0)) begin
        n_fail++; $display("FAIL rand_counts run %0d vec %0d err %0d pass %b, exp %0d %0d %b", r, vec_count, err_count, pass, m_vec, m_err, m_err == 0);
      end
      n_checks++;
      if (first_fail_idx !== 16'(m_fidx) || first_fail_exp !== m_fexp || first_fail_got !== m_fgot) begin
        n_fail++; $display("FAIL rand_first run %0d idx %0d exp %h got %h, exp %0d %h %h", r, first_fail_idx, first_fail_exp, first_fail_got, m_fidx, m_fexp, m_fgot);
      end
    end
  endtask

  task automatic test_stall();
    pulse_start(1);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) send_good($urandom, $urandom, 1'b0);
      else begin @(posedge clk); #1; end
    end
    n_checks++;
    if (vec_count !== 16'd5 || m_vec != 5) begin n_fail++; $display("FAIL stall_accepts vec %0d exp 5", vec_count); end
    n_checks++;
    if (in_ready !== 1'b0 || done !== 1'b1 || pass !== 1'b1) begin n_fail++; $display("FAIL stall_done ready %b done %b pass %b, exp 0 1 1", in_ready, done, pass); end
  endtask

  task automatic test_mid_reset();
    pulse_start(1);
    send_good(32'd10, 32'd20, 1'b0);
    send(32'd1, 32'd1, 1'b0, 32'd7, 1'b0);
    a = 32'd5; b = 32'd6; s = 32'd0; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, in_ready, done} !== 3'b0 || vec_count !== 16'd0 || err_count !== 16'd0 || first_fail_idx !== 16'd0 || first_fail_got !== 33'd0) begin
      n_fail++; $display("FAIL mid_reset busy %b ready %b vec %0d err %0d idx %0d", busy, in_ready, vec_count, err_count, first_fail_idx);
    end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; m_run = 0; model_clear();
    @(posedge clk); #1;
    n_checks++;
    if (err_count !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard err %0d busy %b exp 0 0", err_count, busy); end
  endtask

  task automatic test_restart();
    pulse_start(1);
    send_good(32'd3, 32'd4, 1'b1);
    send_good(32'd5, 32'd6, 1'b0);
    pulse_start(0);
    n_checks++;
    if (vec_count !== 16'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL start_in_run vec %0d busy %b exp 2 1", vec_count, busy); end
    send(32'd7, 32'd8, 1'b0, 32'd99, 1'b0);
    send(32'd1, 32'd2, 1'b0, 32'd77, 1'b1);
    send_good(32'd9, 32'd9, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (err_count !== 16'd2 || first_fail_idx !== 16'd2 || first_fail_got !== {1'b0, 32'd99} || pass !== 1'b0) begin
      n_fail++; $display("FAIL restart_errs err %0d idx %0d got %h pass %b, exp 2 2 63 0", err_count, first_fail_idx, first_fail_got, pass);
    end
    pulse_start(1);
    n_checks++;
    if (done !== 1'b0 || vec_count !== 16'd0 || err_count !== 16'd0 || first_fail_exp !== 33'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_clear done %b vec %0d err %0d exp %h busy %b", done, vec_count, err_count, first_fail_exp, busy);
    end
    for (int i = 0; i < N; i++) send_good($urandom, $urandom, 1'($urandom_range(1)));
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 16'd5) begin n_fail++; $display("FAIL second_run done %b pass %b vec %0d exp 1 1 5", done, pass, vec_count); end
  endtask

  initial begin
    test_reset();
    test_clean(0);
    test_clean(1);
    test_carry(1'b1);
    test_carry(1'b0);
    test_stall();
    test_mid_reset();
    test_restart();
    test_random(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
